// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, line levels,
// default word width and a counter-width helper.
package serial_receiver_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Width of a counter that must hold 0 .. data_w-1.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Line-side and consumer-side signals of the serial receiver.
// slave = the receiver itself, master = the environment driving the line and acks.
interface serial_receiver_if #(
  parameter int DATA_W = serial_receiver_pkg::DEFAULT_DATA_W
);

  logic              data_in;
  logic              data_ack;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport slave (
    input  data_in,
    input  data_ack,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output overrun
  );

  modport master (
    output data_in,
    output data_ack,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  overrun
  );

endinterface

// File: rtl/serial_rx_outreg.sv
// Output holding register of the serial receiver: keeps the last accepted word,
// tracks valid/ack and flags a one-cycle overrun when an unconsumed word is replaced.
module serial_rx_outreg
  import serial_receiver_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // An ack on the same edge consumes the old word, so nothing is lost.
        data_out   <= word;
        data_valid <= 1'b1;
        overrun    <= data_valid & ~ack;
      end else if (ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Serial-to-parallel receiver: start bit, DATA_W data bits MSB-first, optional
// even parity (SERIAL_RX_PARITY_EN), stop bit; registered valid/ack output.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  serial_receiver_if.slave   bus
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              parity_bad;
  logic              load;

`ifdef SERIAL_RX_PARITY_EN
  logic parity_bad_q;
  logic parity_err_q;

  assign parity_bad     = parity_bad_q;
  assign bus.parity_err = parity_err_q;
`else
  assign parity_bad     = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  // NOTE: load is combinational from the STOP state so the output register
  // captures the word on the stop-sampling edge itself, not one cycle later.
  assign load = (state == ST_STOP) && (bus.data_in == STOP_BIT) && !parity_bad;

  assign bus.frame_err = frame_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.data_in == START_BIT) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end

        ST_DATA: begin
          shift_q <= {shift_q[DATA_W-2:0], bus.data_in};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_STOP;
`endif
          end
        end

        ST_PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
          // Even parity: data bits XOR parity bit must be zero.
          parity_bad_q <= (^shift_q) ^ bus.data_in;
          state        <= ST_STOP;
`else
          state <= ST_IDLE;
`endif
        end

        ST_STOP: begin
          frame_err_q  <= (bus.data_in != STOP_BIT);
`ifdef SERIAL_RX_PARITY_EN
          parity_err_q <= parity_bad_q;
          parity_bad_q <= 1'b0;
`endif
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  serial_rx_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .word       (shift_q),
    .ack        (bus.data_ack),
    .data_out   (bus.data_out),
    .data_valid (bus.data_valid),
    .overrun    (bus.overrun)
  );

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed scenarios plus randomized
// frames, all checked against a word-level model of the receiver's rules.
module tb_serial_receiver;
  import serial_receiver_pkg::*;

  localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_receiver_if #(.DATA_W(DW)) bus ();

  serial_receiver #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: the word the consumer should see and whether it is still unconsumed.
  logic [DW-1:0] exp_data  = '0;
  logic          exp_valid = 1'b0;

  function automatic logic [DW+3:0] observed();
    return {bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun};
  endfunction

  // Idle line for n cycles; outputs must hold and flags stay low.
  task automatic idle(input int n, input string name);
    logic [DW+3:0] expv;
    bus.data_in = IDLE_LEVEL;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      expv = {exp_data, exp_valid, 3'b000};
      tests_run++;
      if (observed() !== expv) begin
        tests_failed++;
        $display("FAIL %s idle cycle %0d: got %h want %h", name, c, observed(), expv);
      end
    end
  endtask

  // Standalone one-cycle ack.
  task automatic do_ack(input string name);
    logic [DW+3:0] expv;
    bus.data_ack = 1'b1;
    @(posedge clk); #1;
    bus.data_ack = 1'b0;
    exp_valid = 1'b0;
    expv = {exp_data, exp_valid, 3'b000};
    tests_run++;
    if (observed() !== expv) begin
      tests_failed++;
      $display("FAIL %s ack: got %h want %h", name, observed(), expv);
    end
  endtask

  // One full frame; ack (if set) is presented on the stop-sampling edge.
  task automatic send_frame(input logic [DW-1:0] word, input logic stop,
                            input logic bad_par, input logic ack, input string name);
    logic [DW+3:0] expv;
    logic          perr;
    logic          accept;
    logic          over;
    for (int i = -1; i < DW + int'(PARITY_EN); i++) begin
      if (i < 0)       bus.data_in = START_BIT;
      else if (i < DW) bus.data_in = word[DW-1-i];
      else             bus.data_in = (^word) ^ bad_par;
      @(posedge clk); #1;
      expv = {exp_data, exp_valid, 3'b000};
      tests_run++;
      if (observed() !== expv) begin
        tests_failed++;
        $display("FAIL %s bit %0d: got %h want %h", name, i, observed(), expv);
      end
    end
    bus.data_in  = stop;
    bus.data_ack = ack;
    @(posedge clk); #1;
    bus.data_ack = 1'b0;
    bus.data_in  = IDLE_LEVEL;
    perr   = bad_par && PARITY_EN;
    accept = stop && !perr;
    over   = accept && exp_valid && !ack;
    if (accept) begin
      exp_data  = word;
      exp_valid = 1'b1;
    end else if (ack) begin
      exp_valid = 1'b0;
    end
    expv = {exp_data, exp_valid, !stop, perr, over};
    tests_run++;
    if (observed() !== expv) begin
      tests_failed++;
      $display("FAIL %s stop: got %h want %h (data,valid,ferr,perr,ovr)", name, observed(), expv);
    end
  endtask

  task automatic test_reset();
    logic [DW+3:0] expv;
    expv = '0;
    for (int c = 0; c < 6; c++) begin
      bus.data_in  = ~bus.data_in;
      bus.data_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      tests_run++;
      if (observed() !== expv) begin
        tests_failed++;
        $display("FAIL reset hold %0d: got %h want %h", c, observed(), expv);
      end
    end
    @(negedge clk);
    bus.data_in  = IDLE_LEVEL;
    bus.data_ack = 1'b0;
    rst = 1'b1;
    idle(20, "reset_idle");
  endtask

  task automatic test_single();
    send_frame(8'hF3, 1'b1, 1'b0, 1'b0, "single_f3");
    do_ack("single_f3");
    idle(2, "single_after");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, "b2b_34");
    send_frame(8'h67, 1'b1, 1'b0, 1'b0, "b2b_67");
    idle(2, "b2b_after");
  endtask

  task automatic test_ack_same_edge();
    do_ack("same_edge_clear");
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, "same_edge_34");
    send_frame(8'h78, 1'b1, 1'b0, 1'b1, "same_edge_78");
    idle(1, "same_edge_after");
  endtask

  task automatic test_frame_err();
    send_frame(8'h23, 1'b0, 1'b0, 1'b0, "ferr_23");
    idle(1, "ferr_gap");
    send_frame(8'h90, 1'b1, 1'b0, 1'b0, "ferr_90");
    idle(1, "ferr_after");
  endtask

  task automatic test_line_low();
    for (int k = 0; k < 3; k++) send_frame(8'h00, 1'b0, 1'b0, 1'b0, "line_low");
    idle(3, "line_low_recover");
    send_frame(8'hC6, 1'b1, 1'b0, 1'b0, "line_low_good");
  endtask

  task automatic test_idle_ack();
    do_ack("idle_ack_clear");
    do_ack("idle_ack_ignored");
    idle(1, "idle_ack_after");
  endtask

  task automatic test_parity();
    send_frame(8'h90, 1'b1, 1'b0, 1'b0, "parity_good");
    do_ack("parity_clear");
    send_frame(8'h90, 1'b1, 1'b1, 1'b0, "parity_bad");
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, "parity_and_frame_bad");
    idle(2, "parity_after");
  endtask

  task automatic test_reset_mid();
    logic [DW+3:0] expv;
    logic [DW-1:0] w;
    w = 8'hB4;
    for (int i = -1; i < 4; i++) begin
      bus.data_in = (i < 0) ? START_BIT : w[DW-1-i];
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    exp_data  = '0;
    exp_valid = 1'b0;
    expv = '0;
    tests_run++;
    if (observed() !== expv) begin
      tests_failed++;
      $display("FAIL reset_mid async: got %h want %h", observed(), expv);
    end
    bus.data_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.data_in = IDLE_LEVEL;
    rst = 1'b1;
    idle(3, "reset_mid_idle");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "reset_mid_good");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      send_frame(DW'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), "random");
      idle($urandom_range(0, 2), "random_gap");
      if ($urandom_range(0, 3) == 0) do_ack("random_ack");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.data_in  = IDLE_LEVEL;
    bus.data_ack = 1'b0;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_ack_same_edge();
    test_frame_err();
    test_line_low();
    test_idle_ack();
    test_parity();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Serial-to-parallel receiver: the far end of the team's 8-bit parallel-load serial shifter link. Samples a one-bit-per-clock framed stream (start bit, DATA_W data bits MSB-first, optional parity, stop bit), reassembles the word and presents it on a registered valid/ack output with framing and overrun flags. Sits between the serial line and the byte-consuming logic.

## Interface
- DATA_W, 8, data bits per frame (≥2)
- clk  in  1  rising-edge clock, one line bit per cycle
- rst  in  1  asynchronous reset, active-low
- data_in  in  1  serial line, idles high
- data_ack  in  1  consumer accepts data_out this cycle
- data_out  out  DATA_W  last received word
- data_valid  out  1  data_out holds an unconsumed word
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: unconsumed word overwritten

## Operation
- Reset (rst=0, async): state IDLE; data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0; bit counter and shift register cleared.
- States: IDLE, DATA, PARITY (macro only), STOP.
- IDLE: data_in=0 sampled → DATA, counter=0; otherwise stay.
- DATA: shift data_in in at LSB (first bit ends up MSB); counter increments; after DATA_W bits → PARITY or STOP.
- PARITY: sample parity bit → STOP.
- STOP: data_in=1 → word accepted; data_in=0 → word discarded, frame_err pulses. Always → IDLE.
- Accepted word: data_out ← shift register, data_valid ← 1 on the stop-sampling edge.
- With parity enabled, a parity mismatch discards the word and pulses parity_err, even if stop bit good; if both are bad, both flags pulse.
- data_valid clears on the edge where data_ack=1 is sampled.
- Simultaneous ack and new accepted word: new word loaded, data_valid stays 1, no overrun.
- New accepted word while data_valid=1 and data_ack=0: data_out overwritten, data_valid stays 1, overrun pulses.
- data_ack while data_valid=0: ignored.
- Line held 0 continuously: frame_err on every frame, restart via IDLE each time; no lockup.
- data_in changing inside IDLE glitches nothing; only a sampled 0 starts a frame.

## Timing
- Start bit sampled at edge E0. Data bits at E1..E_DATA_W. Parity at E_DATA_W+1 (macro). Stop bit at the next edge Es = E_DATA_W+1 (no parity) or E_DATA_W+2 (parity).
- data_valid/data_out/error flags update at Es; visible in the cycle after Es.
- Frame length: DATA_W+2 cycles (DATA_W+3 with parity). Back-to-back frames need one IDLE cycle: next start bit sampled no earlier than Es+1.
- Error and overrun flags are high exactly one cycle.
- Async reset mid-frame aborts the frame immediately; first edge after release is in IDLE.

## Configuration
- SERIAL_RX_PARITY_EN defined: PARITY state present; frame carries one even-parity bit (XOR of data bits and parity bit = 0) after the data bits.
- Not defined: no PARITY state, frame = start + data + stop; parity_err port present and tied to 0.

## Structure
- Shared package: state encoding typedef (IDLE, DATA, PARITY, STOP), START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1, default DATA_W.
- One sub-module natural: serial_rx_outreg (output register with valid/ack handling and overrun detection); FSM, counter and shifter stay in top.

## Test plan
- Reset: hold rst=0 with data_in toggling → all outputs 0; release, line idle high 20 cycles → data_valid stays 0.
- Single frame 0xF3: bits 0,1,1,1,1,0,0,1,1,1 from E0 → data_out=0xF3, data_valid=1 after E9; ack one cycle later → data_valid=0.
- Back-to-back 0x34 then 0x67 with one idle cycle, no ack → data_out=0x67, overrun pulses once at second Es, data_valid=1.
- Ack on the same edge as 0x78 completes (0x34 pending) → data_out=0x78, data_valid=1, overrun=0.
- Frame 0x23 with stop bit 0 → frame_err one-cycle pulse, data_out unchanged, data_valid unchanged; next good frame 0x90 → data_out=0x90.
- Macro on: 0x90 with parity bit 0 → accepted; with parity 1 → parity_err pulse, word discarded. Reset asserted at E4 of a frame → IDLE, no flags, no valid.
